// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM pipeline stage controller.
// - wb_src_e : writeback source codes carried in w_Data_S_R_MEM
// - state_e  : memory-access FSM encoding
package mem_stage_ctrl_pkg;

  typedef enum logic [2:0] {
    WB_ALU = 3'd0,
    WB_MEM = 3'd1,
    WB_IMM = 3'd2,
    WB_IN  = 3'd3,
    WB_PC1 = 3'd4
  } wb_src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus.
// - mem_req/mem_we/mem_addr/mem_wdata : request, driven by the stage controller
// - mem_ack/mem_rdata                 : one-cycle completion and read data, driven by memory
interface mem_stage_ctrl_if #(
  parameter int DW = 8
) ();

  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl_mem_wb_mux.sv
// Combinational writeback-source selector, shared with the forwarding path.
// - src      : writeback source code (wb_src_e); codes 5..7 select zero
// - alu_out, mem_data, imm, input_port, pc_plus1 : candidate sources
// - wb_data  : selected value
module mem_wb_mux
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]    src,
  input  logic [DW-1:0] alu_out,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] imm,
  input  logic [DW-1:0] input_port,
  input  logic [DW-1:0] pc_plus1,
  output logic [DW-1:0] wb_data
);

  always_comb begin
    // NOTE: default assignment first so no path leaves wb_data unassigned (no latch).
    wb_data = '0;
    case (src)
      WB_ALU:  wb_data = alu_out;
      WB_MEM:  wb_data = mem_data;
      WB_IMM:  wb_data = imm;
      WB_IN:   wb_data = input_port;
      WB_PC1:  wb_data = pc_plus1;
      default: wb_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: consumes the EX/MEM fields, runs the data-memory access
// over a req/ack handshake, stalls upstream stages while an access is pending,
// and registers the MEM/WB writeback fields and the output port.
// - clk, rst (sync, active-low)
// - *_MEM          : EX/MEM register fields
// - mem            : data-memory bus (master side)
// - stall_mem      : combinational stall to PC, IF/ID, ID/EX, EX/MEM
// - wb_en/addr/data: registered writeback fields
// - out_port       : registered output port
// - mem_err        : sticky access-timeout flag, cleared only by reset
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] Imm_MEM,
  input  logic [DW-1:0] Pc_plus1_MEM,
  input  logic [DW-1:0] ALU_out_MEM,
  input  logic [DW-1:0] Sp_MEM,
  input  logic [DW-1:0] reg_rb_MEM,
  input  logic [DW-1:0] input_port_MEM,
  input  logic          w_E_M_MEM,
  input  logic          w_Add_S_M_MEM,
  input  logic          w_Data_S_M_MEM,
  input  logic          Out_E_MEM,
  input  logic          w_E_R_MEM,
  input  logic          w_Add_S_R_MEM,
  input  logic [2:0]    w_Data_S_R_MEM,
  input  logic [1:0]    ra_MEM,
  input  logic [1:0]    rb_MEM,
  mem_stage_ctrl_if.master mem,
  output logic          stall_mem,
  output logic          wb_en,
  output logic [1:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [DW-1:0] out_port,
  output logic          mem_err
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e        state;
  logic [7:0]    wait_cnt;
  logic [DW-1:0] rd_buf;
  logic          need_acc;
  logic [DW-1:0] mem_src;
  logic [DW-1:0] wb_sel;

  // A load request also counts as an access; a store wins if both are set.
  assign need_acc  = w_E_M_MEM | (w_E_R_MEM & (w_Data_S_R_MEM == WB_MEM));
  // DONE is the one cycle of a memory instruction that lets the pipeline move.
  assign stall_mem = need_acc & (state != DONE);
  // A store that also asks for a memory writeback reads zero, not store-ack data.
  assign mem_src   = w_E_M_MEM ? '0 : rd_buf;

  mem_wb_mux #(.DW(DW)) u_wb_mux (
    .src        (w_Data_S_R_MEM),
    .alu_out    (ALU_out_MEM),
    .mem_data   (mem_src),
    .imm        (Imm_MEM),
    .input_port (input_port_MEM),
    .pc_plus1   (Pc_plus1_MEM),
    .wb_data    (wb_sel)
  );

  // Access FSM; all mem_* outputs are registered and frozen during ACCESS.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      // NOTE: rd_buf is a single register, not an array, so resetting it is cheap and keeps stale data out of writeback.
      rd_buf        <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (need_acc) begin
            // NOTE: non-blocking assignments: every register here updates from pre-edge values.
            state         <= ACCESS;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= w_E_M_MEM;
            mem.mem_addr  <= w_Add_S_M_MEM  ? Sp_MEM       : ALU_out_MEM;
            mem.mem_wdata <= w_Data_S_M_MEM ? Pc_plus1_MEM : reg_rb_MEM;
          end
        end
        ACCESS: begin
          // An ack on the last allowed cycle still counts as success.
          if (mem.mem_ack) begin
            rd_buf      <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == LAST_WAIT) begin
              mem.mem_req <= 1'b0;
              mem_err     <= 1'b1;
              rd_buf      <= '0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB fields advance only on unstalled edges; stalled edges insert a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      out_port <= '0;
    end else if (!stall_mem) begin
      wb_en   <= w_E_R_MEM;
      wb_addr <= w_Add_S_R_MEM ? rb_MEM : ra_MEM;
      wb_data <= wb_sel;
      if (Out_E_MEM) out_port <= reg_rb_MEM;
    end else begin
      wb_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] Imm_MEM, Pc_plus1_MEM, ALU_out_MEM, Sp_MEM, reg_rb_MEM, input_port_MEM;
  logic          w_E_M_MEM, w_Add_S_M_MEM, w_Data_S_M_MEM, Out_E_MEM, w_E_R_MEM, w_Add_S_R_MEM;
  logic [2:0]    w_Data_S_R_MEM;
  logic [1:0]    ra_MEM, rb_MEM;
  logic          stall_mem, wb_en, mem_err;
  logic [1:0]    wb_addr;
  logic [DW-1:0] wb_data, out_port;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DW(DW)) mem_if ();

  mem_stage_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .Imm_MEM        (Imm_MEM),
    .Pc_plus1_MEM   (Pc_plus1_MEM),
    .ALU_out_MEM    (ALU_out_MEM),
    .Sp_MEM         (Sp_MEM),
    .reg_rb_MEM     (reg_rb_MEM),
    .input_port_MEM (input_port_MEM),
    .w_E_M_MEM      (w_E_M_MEM),
    .w_Add_S_M_MEM  (w_Add_S_M_MEM),
    .w_Data_S_M_MEM (w_Data_S_M_MEM),
    .Out_E_MEM      (Out_E_MEM),
    .w_E_R_MEM      (w_E_R_MEM),
    .w_Add_S_R_MEM  (w_Add_S_R_MEM),
    .w_Data_S_R_MEM (w_Data_S_R_MEM),
    .ra_MEM         (ra_MEM),
    .rb_MEM         (rb_MEM),
    .mem            (mem_if),
    .stall_mem      (stall_mem),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .out_port       (out_port),
    .mem_err        (mem_err)
  );

  typedef struct packed {
    logic [7:0] imm, pc1, alu, sp, rb_val, inp;
    logic       we_m, add_s_m, data_s_m, out_e, we_r, add_s_r;
    logic [2:0] src;
    logic [1:0] ra, rb;
  } instr_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  typedef struct packed {
    logic       en;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] outp;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  req_t req_q[$];
  exp_t exp_q[$];

  // Memory model controls
  int         ack_delay = -1;   // ACCESS cycles before ack; negative = never
  logic [7:0] rdata_val = 8'h00;
  logic       stray_ack = 1'b0;

  // Architectural expectations carried across instructions
  logic       exp_err = 1'b0;
  logic [7:0] exp_out = 8'h00;

  // Memory responder: checks each request against the scoreboard on every
  // cycle it is held, and returns ack after ack_delay waiting cycles.
  int   wait_seen = 0;
  logic req_seen  = 1'b0;
  req_t cur_req;
  always @(negedge clk) begin
    mem_if.mem_ack   = stray_ack;
    mem_if.mem_rdata = rdata_val;
    if (mem_if.mem_req === 1'b1) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req got=%h", {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata});
          cur_req = {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata};
        end else begin
          cur_req = req_q.pop_front();
        end
      end
      checks++;
      if ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !== cur_req) begin
        errors++;
        $display("FAIL req_fields got we/addr/wdata=%h expected=%h",
                 {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, cur_req);
      end
      if (wait_seen == ack_delay) mem_if.mem_ack = 1'b1;
      wait_seen++;
    end else begin
      req_seen  = 1'b0;
      wait_seen = 0;
    end
  end

  task automatic drive(input instr_t i);
    Imm_MEM        = i.imm;
    Pc_plus1_MEM   = i.pc1;
    ALU_out_MEM    = i.alu;
    Sp_MEM         = i.sp;
    reg_rb_MEM     = i.rb_val;
    input_port_MEM = i.inp;
    w_E_M_MEM      = i.we_m;
    w_Add_S_M_MEM  = i.add_s_m;
    w_Data_S_M_MEM = i.data_s_m;
    Out_E_MEM      = i.out_e;
    w_E_R_MEM      = i.we_r;
    w_Add_S_R_MEM  = i.add_s_r;
    w_Data_S_R_MEM = i.src;
    ra_MEM         = i.ra;
    rb_MEM         = i.rb;
  endtask

  function automatic logic [7:0] wb_value(input instr_t i, input logic [7:0] rd);
    case (i.src)
      3'd0:    return i.alu;
      3'd1:    return i.we_m ? 8'h00 : rd;
      3'd2:    return i.imm;
      3'd3:    return i.inp;
      3'd4:    return i.pc1;
      default: return 8'h00;
    endcase
  endfunction

  // Issue one instruction, wait (bounded) for its retire edge, and compare.
  // Called between edges; leaves the inputs as a bubble afterwards.
  task automatic run_instr(input string name, input instr_t i, input int delay,
                           input logic [7:0] rdata);
    logic       need, to_path, done;
    logic [7:0] rd;
    int         stalls, exp_stalls;
    exp_t       e, got;
    need    = i.we_m | (i.we_r & (i.src == 3'd1));
    to_path = need && (delay < 0 || delay > TIMEOUT - 1);
    rd      = to_path ? 8'h00 : rdata;
    ack_delay = delay;
    rdata_val = rdata;
    if (need) req_q.push_back({i.we_m, (i.add_s_m ? i.sp : i.alu), (i.data_s_m ? i.pc1 : i.rb_val)});
    if (i.out_e) exp_out = i.rb_val;
    if (to_path) exp_err = 1'b1;
    e = {i.we_r, (i.add_s_r ? i.rb : i.ra), wb_value(i, rd), exp_out};
    exp_q.push_back(e);
    exp_stalls = !need ? 0 : (to_path ? TIMEOUT + 1 : delay + 2);
    drive(i);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stall_mem === 1'b0) begin
        @(posedge clk); #1;
        got = {wb_en, wb_addr, wb_data, out_port};
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s_wb got en/addr/data/out=%h expected=%h", name, got, e);
        end
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk); #1;
        checks++;
        if (wb_en !== 1'b0) begin
          errors++;
          $display("FAIL %s_bubble got wb_en=%b expected=0", name, wb_en);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_retire_timeout no retire within 100 cycles", name);
      void'(exp_q.pop_front());
    end
    checks++;
    if (stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s_stall_cycles got=%0d expected=%0d", name, stalls, exp_stalls);
    end
    checks++;
    if (mem_err !== exp_err) begin
      errors++;
      $display("FAIL %s_mem_err got=%b expected=%b", name, mem_err, exp_err);
    end
    checks++;
    if (mem_if.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_after_retire got=%b expected=0", name, mem_if.mem_req);
    end
    drive('0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
         stall_mem, wb_en, wb_addr, wb_data, out_port, mem_err} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h expected=0",
               {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
                stall_mem, wb_en, wb_addr, wb_data, out_port, mem_err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_wb();
    instr_t i;
    i = '0; i.we_r = 1'b1; i.src = 3'd0; i.alu = 8'h3C; i.ra = 2'd2;
    run_instr("alu", i, 0, 8'h00);
    // Remaining sources, destination rb
    for (int s = 2; s <= 5; s++) begin
      i = '0; i.we_r = 1'b1; i.add_s_r = 1'b1; i.src = 3'(s);
      i.imm = 8'h11; i.inp = 8'h22; i.pc1 = 8'h33; i.alu = 8'h44;
      i.ra = 2'd0; i.rb = 2'(s);
      run_instr("src", i, 0, 8'h00);
    end
  endtask

  task automatic test_load();
    instr_t i;
    i = '0; i.we_r = 1'b1; i.src = 3'd1; i.alu = 8'h10; i.ra = 2'd1;
    run_instr("load", i, 2, 8'hA5);
  endtask

  task automatic test_push_pc();
    instr_t i;
    i = '0; i.we_m = 1'b1; i.add_s_m = 1'b1; i.data_s_m = 1'b1;
    i.sp = 8'hFF; i.pc1 = 8'h21; i.alu = 8'h99; i.rb_val = 8'h77;
    run_instr("push_pc", i, 1, 8'hEE);
  endtask

  task automatic test_write_priority();
    instr_t i;
    i = '0; i.we_m = 1'b1; i.we_r = 1'b1; i.src = 3'd1;
    i.alu = 8'h40; i.rb_val = 8'h6B; i.ra = 2'd3;
    run_instr("store_wb", i, 0, 8'h77);
  endtask

  task automatic test_back_to_back();
    instr_t a, b;
    a = '0; a.we_r = 1'b1; a.src = 3'd1; a.alu = 8'h20; a.ra = 2'd1;
    b = '0; b.we_r = 1'b1; b.src = 3'd1; b.alu = 8'h21; b.rb = 2'd2; b.add_s_r = 1'b1;
    run_instr("b2b_first", a, 0, 8'hC1);
    run_instr("b2b_second", b, 3, 8'hC2);
  endtask

  task automatic test_ack_on_timeout();
    instr_t i;
    i = '0; i.we_r = 1'b1; i.src = 3'd1; i.alu = 8'h30; i.ra = 2'd3;
    run_instr("ack_last", i, TIMEOUT - 1, 8'h5E);
  endtask

  task automatic test_timeout();
    instr_t i;
    i = '0; i.we_r = 1'b1; i.src = 3'd1; i.alu = 8'h50; i.ra = 2'd2;
    run_instr("timeout", i, -1, 8'hDD);
    i.alu = 8'h51;
    run_instr("after_timeout", i, 1, 8'h3B);
  endtask

  task automatic test_out_port();
    instr_t i;
    i = '0; i.out_e = 1'b1; i.rb_val = 8'h5A;
    run_instr("out_port", i, 0, 8'h00);
  endtask

  task automatic test_reset_mid_access();
    instr_t i;
    i = '0; i.we_r = 1'b1; i.src = 3'd1; i.alu = 8'h60; i.ra = 2'd1;
    ack_delay = -1;
    req_q.push_back({1'b0, 8'h60, 8'h00});
    drive(i);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (mem_if.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_req got=%b expected=1", mem_if.mem_req);
    end
    rst = 1'b0;
    drive('0);
    @(posedge clk); #1;
    checks++;
    if ({mem_if.mem_req, out_port, mem_err, wb_en, stall_mem} !== '0) begin
      errors++;
      $display("FAIL mid_access_reset got req/out/err/en/stall=%h expected=0",
               {mem_if.mem_req, out_port, mem_err, wb_en, stall_mem});
    end
    rst = 1'b1;
    exp_err = 1'b0;
    exp_out = 8'h00;
    stray_ack = 1'b1;
    rdata_val = 8'hBB;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_if.mem_req, mem_err, stall_mem} !== 3'b000) begin
      errors++;
      $display("FAIL stray_ack got req/err/stall=%b expected=000",
               {mem_if.mem_req, mem_err, stall_mem});
    end
    // Normal operation afterwards
    i.alu = 8'h61;
    run_instr("after_reset", i, 0, 8'h4D);
  endtask

  initial begin
    test_reset();
    test_alu_wb();
    test_load();
    test_push_pc();
    test_write_priority();
    test_back_to_back();
    test_ack_on_timeout();
    test_timeout();
    test_out_port();
    test_reset_mid_access();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register. It takes the *_MEM control and data fields and performs the data-memory access through a req/ack handshake.
- Stalls the pipeline while an access is outstanding, drives the output port, and produces registered MEM/WB writeback fields.
- Sits between the EX/MEM register outputs and the MEM/WB register and data memory.

Parameters:
- DW, 8, datapath and memory address/data width.
- TIMEOUT, 15, maximum ACCESS-state cycles waiting for mem_ack before abort (range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- Imm_MEM, Pc_plus1_MEM, ALU_out_MEM, Sp_MEM, reg_rb_MEM, input_port_MEM  in  DW each  EX/MEM data fields.
- w_E_M_MEM  in  1  memory write instruction.
- w_Add_S_M_MEM  in  1  memory address select: 0=ALU_out_MEM, 1=Sp_MEM.
- w_Data_S_M_MEM  in  1  memory write data select: 0=reg_rb_MEM, 1=Pc_plus1_MEM.
- Out_E_MEM  in  1  output-port write.
- w_E_R_MEM  in  1  register writeback enable.
- w_Add_S_R_MEM  in  1  destination select: 0=ra_MEM, 1=rb_MEM.
- w_Data_S_R_MEM  in  3  writeback source: 0=ALU_out, 1=memory read, 2=Imm, 3=input_port, 4=Pc_plus1, 5..7=8'h00.
- ra_MEM, rb_MEM  in  2 each  register indices.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write strobe qualifying mem_req.
- mem_addr  out  DW  access address.
- mem_wdata  out  DW  write data.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  DW  read data, valid with mem_ack.
- stall_mem  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- wb_en  out  1  registered writeback enable to MEM/WB.
- wb_addr  out  2  registered destination register.
- wb_data  out  DW  registered writeback data.
- out_port  out  DW  registered output port.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- need_acc = w_E_M_MEM | (w_E_R_MEM & w_Data_S_R_MEM==1).
- Write has priority if both terms are set; the writeback source then reads 8'h00.
- States:
  - IDLE: if need_acc, go to ACCESS and register mem_req=1, mem_we=w_E_M_MEM, mem_addr, and mem_wdata (per the select inputs).
  - ACCESS: hold all mem_* outputs stable. On mem_ack: capture mem_rdata into rd_buf, mem_req<=0, go to DONE. Otherwise increment wait_cnt; when wait_cnt==TIMEOUT-1: mem_req<=0, mem_err<=1, rd_buf<=8'h00, go to DONE.
  - DONE: go to IDLE next cycle and clear wait_cnt.
- mem_ack and the timeout in the same cycle: ack wins, and mem_err does not set.
- mem_ack outside ACCESS is ignored.
- stall_mem = need_acc & (state!=DONE). It is high from the first cycle the instruction is present in IDLE.
- Retire edge = any rising edge with stall_mem==0. On that edge:
  - wb_en <= w_E_R_MEM
  - wb_addr <= w_Add_S_R_MEM ? rb_MEM : ra_MEM
  - wb_data <= selected source (rd_buf for code 1)
  - if Out_E_MEM, out_port <= reg_rb_MEM
- On a non-retire edge, wb_en <= 0 (bubble); wb_addr, wb_data and out_port hold.
- Latency:
  - Non-memory instruction: writeback fields are visible 1 cycle after it appears.
  - Memory instruction: ack-delay cycles + 3 (IDLE, ACCESS..., DONE, then retire edge).
- Back-to-back memory instructions: DONE->IDLE, and the next access starts on the following cycle. There is no overlap.
- Reset (rst==0 at an edge): state=IDLE, wait_cnt=0, rd_buf=0, and all outputs 0 including mem_err.
  - Mid-access reset drops mem_req on that same edge.
  - A late mem_ack after reset is ignored.
- mem_err clears only on reset.

Decomposition:
- Shared package/header holds:
  - WB source codes: WB_ALU=0, WB_MEM=1, WB_IMM=2, WB_IN=3, WB_PC1=4.
  - State encodings: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- One natural sub-module, mem_wb_mux: a combinational writeback-source selector reused by the forwarding logic.

Test Plan:
- ALU writeback: w_E_R=1, src=0, ALU_out=8'h3C, ra=2, w_Add_S_R=0 -> stall_mem stays 0; next edge wb_en=1, wb_addr=2, wb_data=8'h3C.
- Load with ack after 2 cycles: w_E_R=1, src=1, ALU_out=8'h10, mem_rdata=8'hA5 -> mem_req=1, mem_we=0, mem_addr=8'h10; stall_mem=1 for 4 cycles; then wb_data=8'hA5.
- Push PC (call): w_E_M=1, w_Add_S_M=1, w_Data_S_M=1, Sp=8'hFF, Pc_plus1=8'h21 -> mem_addr=8'hFF, mem_wdata=8'h21, mem_we=1; wb_en=0 at retire.
- Timeout: TIMEOUT=15, load with mem_ack never asserted -> mem_req drops after 15 ACCESS cycles, mem_err=1, wb_data=8'h00; a subsequent load still completes normally.
- Ack on the timeout cycle -> rdata is captured and mem_err stays 0.
- Output port plus reset: Out_E=1, reg_rb=8'h5A -> out_port=8'h5A after retire. Then assert rst=0 mid-access -> mem_req=0 and out_port=0 on the next edge, and a stray mem_ack afterwards is ignored.
